// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared word width and state/grant encodings for the memory port arbiter
package mem_port_arbiter_pkg;
    localparam int WORD_SIZE = 16;
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
    typedef enum logic {GNT_IF, GNT_D} gnt_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester handshakes and memory strobes shared by the arbiter and its users
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;
    logic                 if_req;
    logic [WORD_SIZE-1:0] if_addr;
    logic                 if_ack;
    logic [WORD_SIZE-1:0] if_rdata;
    logic                 d_req;
    logic                 d_we;
    logic [WORD_SIZE-1:0] d_addr;
    logic [WORD_SIZE-1:0] d_wdata;
    logic                 d_ack;
    logic [WORD_SIZE-1:0] d_rdata;
    logic                 readM;
    logic                 writeM;
    logic [WORD_SIZE-1:0] address;
    logic                 mem_ack;
    logic                 bus_error;
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack,
        output if_ack, if_rdata, d_ack, d_rdata, readM, writeM, address, bus_error
    );
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack,
        input  if_ack, if_rdata, d_ack, d_rdata, readM, writeM, address, bus_error
    );
endinterface

// File: rtl/mem_timeout_timer.sv
// mem_timeout_timer: clearable up-counter flagging the last allowed wait cycle of a memory access
module mem_timeout_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [7:0] cnt_q, cnt_d;

    // clear wins over count so a new grant always starts from zero
    always_comb cnt_d = clr ? '0 : (en ? cnt_q + 8'd1 : cnt_q);

    // counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign tc = cnt_q == 8'(TIMEOUT - 1);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serializes fetch and data requests onto one memory port with a per-access watchdog
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mem_port_arbiter_if.slave    bus,
    inout  wire  [WORD_SIZE-1:0] data
);
    typedef logic [WORD_SIZE-1:0] word_t;

    state_t state_q, state_d;
    gnt_t   owner_q, owner_d, last_q, last_d;
    logic   we_q, we_d, readm_q, readm_d, writem_q, writem_d;
    logic   if_ack_q, if_ack_d, d_ack_q, d_ack_d, bus_error_q, bus_error_d;
    word_t  addr_q, addr_d, wdata_q, wdata_d, if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic   tmr_clr, tmr_en, tmr_tc, finish;
    word_t  rdata_in;

    mem_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk(clk),
        .reset_n(reset_n),
        .clr(tmr_clr),
        .en(tmr_en),
        .tc(tmr_tc)
    );

    // an ack in the last wait cycle still counts as success; a timeout returns zero
    assign finish   = bus.mem_ack || tmr_tc;
    assign rdata_in = bus.mem_ack ? data : '0;

    // next-state and next-output logic; strobes and acks are computed for the state being entered
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        bus_error_d = bus_error_q;
        readm_d     = 1'b0;
        writem_d    = 1'b0;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    owner_d  = (bus.if_req && bus.d_req) ? ((last_q == GNT_IF) ? GNT_D : GNT_IF)
                                                         : (bus.d_req ? GNT_D : GNT_IF);
                    last_d   = owner_d;
                    we_d     = (owner_d == GNT_D) && bus.d_we;
                    addr_d   = (owner_d == GNT_D) ? bus.d_addr : bus.if_addr;
                    wdata_d  = bus.d_wdata;
                    readm_d  = !we_d;
                    writem_d = we_d;
                    tmr_clr  = 1'b1;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (finish) begin
                    state_d     = ST_DONE;
                    bus_error_d = bus_error_q | ~bus.mem_ack;
                    if_ack_d    = owner_q == GNT_IF;
                    d_ack_d     = owner_q == GNT_D;
                    if_rdata_d  = (owner_q == GNT_IF) ? rdata_in : if_rdata_q;
                    d_rdata_d   = (owner_q == GNT_D && !we_q) ? rdata_in : d_rdata_q;
                end else begin
                    tmr_en   = 1'b1;
                    readm_d  = !we_q;
                    writem_d = we_q;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // state and registered outputs; reset abandons any access in flight without an ack
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= GNT_IF;
            last_q      <= GNT_IF;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            bus_error_q <= 1'b0;
            readm_q     <= 1'b0;
            writem_q    <= 1'b0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            bus_error_q <= bus_error_d;
            readm_q     <= readm_d;
            writem_q    <= writem_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
        end
    end

    assign bus.readM     = readm_q;
    assign bus.writeM    = writem_q;
    assign bus.address   = addr_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.bus_error = bus_error_q;
    assign data          = writem_q ? wdata_q : 'z;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized transactions checked against a transaction-level model
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;
    localparam int TO = 15;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 mem_drive = 1'b0;
    logic [WORD_SIZE-1:0] mem_val = '0;
    wire  [WORD_SIZE-1:0] data;
    int                   errors = 0;
    int                   checks = 0;
    logic                 last_m = 1'b0;
    logic                 err_m = 1'b0;
    logic [15:0]          drd_m = '0;

    mem_port_arbiter_if bus_if();

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus_if),
        .data(data)
    );

    assign data = mem_drive ? mem_val : 'z;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        bus_if.if_req = 1'b0;
        bus_if.d_req = 1'b0;
        bus_if.mem_ack = 1'b0;
        mem_drive = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        last_m = 1'b0;
        err_m = 1'b0;
        drd_m = '0;
        @(negedge clk);
    endtask

    // one transaction from an idle arbiter; lat = BUSY cycle on which memory acks (0 or >TO: never)
    task automatic serve(input logic rq_if, input logic rq_d, input logic we,
                         input logic [15:0] ia, input logic [15:0] da, input logic [15:0] wd,
                         input int lat, input logic [15:0] rv, output logic gd);
        logic own, ewe, hit, got, both, addr_bad, data_bad, done_strb;
        logic [15:0] eaddr, rif, rd;
        int ebusy, busy, nr, nw, cyc;
        own   = (rq_if && rq_d) ? !last_m : rq_d;
        last_m = own;
        ewe   = own && we;
        eaddr = own ? da : ia;
        hit   = lat >= 1 && lat <= TO;
        ebusy = hit ? lat : TO;
        bus_if.if_req = rq_if;
        bus_if.d_req = rq_d;
        bus_if.d_we = we;
        bus_if.if_addr = ia;
        bus_if.d_addr = da;
        bus_if.d_wdata = wd;
        mem_drive = !ewe;
        mem_val = rv;
        {got, both, addr_bad, data_bad, done_strb} = '0;
        {busy, nr, nw, cyc} = '0;
        gd = 1'b0;
        rif = '0;
        rd = '0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            bus_if.mem_ack = 1'b0;
            if (bus_if.if_ack && bus_if.d_ack) both = 1'b1;
            if (bus_if.if_ack || bus_if.d_ack) begin
                got = 1'b1;
                cyc = c;
                gd = bus_if.d_ack;
                rif = bus_if.if_rdata;
                rd = bus_if.d_rdata;
                done_strb = bus_if.readM | bus_if.writeM;
            end else if (bus_if.readM || bus_if.writeM) begin
                busy++;
                nr += int'(bus_if.readM);
                nw += int'(bus_if.writeM);
                if (bus_if.address !== eaddr) addr_bad = 1'b1;
                if (data !== (ewe ? wd : rv)) data_bad = 1'b1;
                if (busy == lat) bus_if.mem_ack = 1'b1;
            end
        end
        bus_if.mem_ack = 1'b0;
        mem_drive = 1'b0;
        chk("ack_seen", got, 1);
        chk("owner", gd, own);
        chk("latency", cyc, ebusy + 1);
        chk("busy_cycles", busy, ebusy);
        chk("readM_cycles", nr, ewe ? 0 : ebusy);
        chk("writeM_cycles", nw, ewe ? ebusy : 0);
        chk("address", addr_bad, 0);
        chk("data_bus", data_bad, 0);
        chk("ack_overlap", both, 0);
        chk("done_strobes", done_strb, 0);
        err_m = err_m | !hit;
        if (!own) chk("if_rdata", rif, hit ? rv : 16'h0);
        else begin
            if (!we) drd_m = hit ? rv : 16'h0;
            chk("d_rdata", rd, drd_m);
        end
        chk("bus_error", bus_if.bus_error, err_m);
        if (own) bus_if.d_req = 1'b0;
        else     bus_if.if_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic g0, g1, g2, g3, g;
        bus_if.if_req = 1'b0;
        bus_if.if_addr = '0;
        bus_if.d_req = 1'b0;
        bus_if.d_we = 1'b0;
        bus_if.d_addr = '0;
        bus_if.d_wdata = '0;
        bus_if.mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_readM", bus_if.readM, 0);
        chk("rst_writeM", bus_if.writeM, 0);
        chk("rst_acks", {bus_if.if_ack, bus_if.d_ack}, 0);
        chk("rst_address", bus_if.address, 0);
        chk("rst_bus_error", bus_if.bus_error, 0);
        reset_n = 1'b1;
        @(negedge clk);
        // reset in the middle of a write access
        bus_if.d_req = 1'b1;
        bus_if.d_we = 1'b1;
        bus_if.d_addr = 16'h0100;
        bus_if.d_wdata = 16'h1234;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_writeM", bus_if.writeM, 1);
        #2 reset_n = 1'b0;
        bus_if.d_req = 1'b0;
        #1;
        chk("mid_rst_readM", bus_if.readM, 0);
        chk("mid_rst_writeM", bus_if.writeM, 0);
        chk("mid_rst_acks", {bus_if.if_ack, bus_if.d_ack}, 0);
        chk("mid_rst_bus_error", bus_if.bus_error, 0);
        chk("mid_rst_data_released", data !== 16'h1234, 1);
        @(negedge clk);
        reset_n = 1'b1;
        last_m = 1'b0;
        err_m = 1'b0;
        drd_m = '0;
        @(negedge clk);
        serve(1, 0, 0, 16'h0010, 16'h0, 16'h0, 2, 16'hBEEF, g);
        // single fetch and delayed write
        serve(1, 0, 0, 16'h0020, 16'h0, 16'h0, 1, 16'hA5A5, g);
        serve(0, 1, 1, 16'h0, 16'h0100, 16'h1234, 4, 16'h0, g);
        // contention from reset alternates starting with data
        do_reset();
        serve(1, 1, 0, 16'h0030, 16'h0130, 16'h0, 1, 16'h1111, g0);
        serve(1, 1, 0, 16'h0031, 16'h0131, 16'h0, 2, 16'h2222, g1);
        serve(1, 1, 1, 16'h0032, 16'h0132, 16'h9999, 1, 16'h3333, g2);
        serve(1, 1, 0, 16'h0033, 16'h0133, 16'h0, 3, 16'h4444, g3);
        chk("contention_order", {g0, g1, g2, g3}, 4'b1010);
        // watchdog timeout then a normal fetch with the error still latched
        serve(0, 1, 0, 16'h0, 16'h0200, 16'h0, 0, 16'h5555, g);
        serve(1, 0, 0, 16'h0300, 16'h0, 16'h0, 3, 16'h7777, g);
        // ack on the final wait cycle wins over the timeout
        do_reset();
        serve(0, 1, 0, 16'h0, 16'h0400, 16'h0, TO, 16'hC3C3, g);
        // random traffic
        for (int i = 0; i < 40; i++) begin
            logic ri, rdq, w;
            ri  = 1'($urandom_range(0, 1));
            rdq = ri ? 1'($urandom_range(0, 1)) : 1'b1;
            w   = 1'($urandom_range(0, 1));
            serve(ri, rdq, w, 16'($urandom), 16'($urandom), 16'($urandom),
                  int'($urandom_range(0, TO + 1)), 16'($urandom), g);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
